// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I memory-access types for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {LSU_IDLE, LSU_BUSY, LSU_DONE} lsu_state_t;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_CONFLICT, ERR_TIMEOUT
  } lsu_err_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] offset;
  } lsu_req_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane formatting and legality for RV32I loads/stores; purely combinational.
// Latency: 0 cycles; backpressure: none (no state).
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        legal,
  output logic        misalign
);

  rv32i_word shifted;
  logic      bad_f3;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    mask       = '0;
    store_data = wdata;
    load_data  = shifted;
    bad_f3     = 1'b0;
    misalign   = 1'b0;
    if (store) begin
      case (store_funct3_t'(funct3))
        sb: begin
          mask       = 4'b0001 << offset;
          store_data = {4{wdata[7:0]}};
        end
        sh: begin
          mask       = 4'b0011 << {offset[1], 1'b0};
          store_data = {2{wdata[15:0]}};
          misalign   = offset[0];
        end
        sw: begin
          mask     = 4'b1111;
          misalign = |offset;
        end
        default: bad_f3 = 1'b1;
      endcase
    end else begin
      mask = 4'b1111;
      case (load_funct3_t'(funct3))
        lb:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        lbu: load_data = {24'b0, shifted[7:0]};
        lh: begin
          load_data = {{16{shifted[15]}}, shifted[15:0]};
          misalign  = offset[0];
        end
        lhu: begin
          load_data = {16'b0, shifted[15:0]};
          misalign  = offset[0];
        end
        lw: begin
          load_data = rdata;
          misalign  = |offset;
        end
        default: bad_f3 = 1'b1;
      endcase
    end
  end

  assign legal = !bad_f3 && !misalign;

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: dmem request/response FSM with a response watchdog.
// Latency: >=3 cycles accept-to-done; backpressure: stall_o holds upstream until DONE.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        err_o,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t       state;
  lsu_req_t         req;
  lsu_err_t         err_kind;
  logic [CNT_W-1:0] cnt;

  logic           mem_op, busy, conflict;
  logic           a_store, a_legal, a_misalign;
  logic [2:0]     a_f3;
  logic [1:0]     a_off;
  rv32i_mem_wmask a_mask;
  rv32i_word      a_sdata, a_ldata;

  assign mem_op   = valid_i & (mem_read_i | mem_write_i);
  assign busy     = (state == LSU_BUSY);
  assign conflict = mem_read_i & mem_write_i;
  assign stall_o  = ((state == LSU_IDLE) && mem_op) || busy;
  assign err_o    = (err_kind != ERR_NONE);

  // Legality is judged on live inputs in IDLE; load formatting uses the latched request.
  assign a_store = busy ? dmem_write   : mem_write_i;
  assign a_f3    = busy ? req.funct3   : funct3_i;
  assign a_off   = busy ? req.offset   : addr_i[1:0];

  mem_stage_lsu_align u_align (
    .store      (a_store),
    .funct3     (a_f3),
    .offset     (a_off),
    .wdata      (wdata_i),
    .rdata      (dmem_rdata),
    .mask       (a_mask),
    .store_data (a_sdata),
    .load_data  (a_ldata),
    .legal      (a_legal),
    .misalign   (a_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= LSU_IDLE;
      req              <= '0;
      cnt              <= '0;
      err_kind         <= ERR_NONE;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      done_o           <= 1'b0;
      load_data_o      <= '0;
    end else begin
      done_o   <= 1'b0;
      err_kind <= ERR_NONE;
      case (state)
        LSU_IDLE: begin
          if (mem_op) begin
            if (conflict || !a_legal) begin
              err_kind <= conflict ? ERR_CONFLICT : (a_misalign ? ERR_MISALIGN : ERR_ILLEGAL);
              done_o   <= 1'b1;
              state    <= LSU_DONE;
            end else begin
              req              <= '{funct3: funct3_i, offset: addr_i[1:0]};
              dmem_read        <= mem_read_i;
              dmem_write       <= mem_write_i;
              dmem_address     <= {addr_i[31:2], 2'b00};
              dmem_wdata       <= a_sdata;
              dmem_byte_enable <= a_mask;
              cnt              <= '0;
              state            <= LSU_BUSY;
            end
          end
        end
        LSU_BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (dmem_read) load_data_o <= a_ldata;
            done_o     <= 1'b1;
            state      <= LSU_DONE;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            load_data_o <= '0;
            err_kind    <= ERR_TIMEOUT;
            done_o      <= 1'b1;
            state       <= LSU_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level timeline model.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall_o, done_o, err_o;
  logic [31:0] load_data_o;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_enable;

  int checks = 0;
  int errors = 0;

  logic        chk_en;
  logic        exp_stall, exp_done, exp_err, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wdata, exp_load;
  logic [3:0]  exp_be;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  int          cap_req;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_i          (valid),
    .mem_read_i       (mem_read),
    .mem_write_i      (mem_write),
    .funct3_i         (funct3),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .stall_o          (stall_o),
    .done_o           (done_o),
    .load_data_o      (load_data_o),
    .err_o            (err_o),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: access size, alignment and lane arithmetic.
  function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int sz;
    int off;
    off = int'(a[1:0]);
    if (rd && wr) return 1'b0;
    if (rd) begin
      if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
      sz = 1 << int'(f3[1:0]);
    end else begin
      if (f3 > 3'd2) return 1'b0;
      sz = 1 << int'(f3);
    end
    return (off % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdat);
    logic [31:0] w;
    w = rdat >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin w = w & 32'hFF;   if (w >= 32'd128)   w = w - 32'd256;   end
      3'd1: begin w = w & 32'hFFFF; if (w >= 32'd32768) w = w - 32'd65536; end
      3'd2: w = rdat;
      3'd4: w = w & 32'hFF;
      3'd5: w = w & 32'hFFFF;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [1:0] off);
    int sz;
    sz = 1 << int'(f3);
    return 4'(((1 << sz) - 1) << int'(off));
  endfunction

  function automatic logic [31:0] m_sdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] lo8, lo16;
    lo8  = wd & 32'hFF;
    lo16 = wd & 32'hFFFF;
    if (f3 == 3'd0) return lo8 * 32'h0101_0101;
    if (f3 == 3'd1) return lo16 * 32'h0001_0001;
    return wd;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check1("stall_o", stall_o, exp_stall);
      check1("done_o", done_o, exp_done);
      check1("err_o", err_o, exp_err);
      check1("dmem_read", dmem_read, exp_rd);
      check1("dmem_write", dmem_write, exp_wr);
      check32("load_data_o", load_data_o, exp_load);
      if (exp_rd || exp_wr) begin
        check32("dmem_address", dmem_address, exp_addr);
        check32("dmem_byte_enable", 32'(dmem_byte_enable), 32'(exp_be));
        if (exp_wr) check32("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      valid     = 1'($urandom);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      funct3    = 3'($urandom);
      addr      = $urandom;
      dmem_resp = 1'($urandom);
      dmem_rdata = $urandom;
      set_idle_exp();
    end
  endtask

  // d = busy-cycle index at which dmem_resp is raised; d >= TO means it never comes.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int d);
    bit legal, tmo;
    int nb;
    legal   = m_legal(rd, wr, f3, a);
    tmo     = 1'b0;
    cap_req = 0;
    step();
    valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    dmem_resp = 1'($urandom); dmem_rdata = $urandom;
    set_idle_exp();
    exp_stall = 1'b1;
    if (legal) begin
      tmo = (d >= TO);
      nb  = tmo ? TO : d + 1;
      for (int i = 0; i < nb; i++) begin
        step();
        exp_stall = 1'b1;
        exp_rd    = rd;
        exp_wr    = wr;
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = rd ? 4'hF : m_mask(f3, a[1:0]);
        exp_wdata = m_sdata(f3, wd);
        dmem_resp  = (i == d);
        dmem_rdata = (i == d) ? rdat : $urandom;
        cap_req += int'(dmem_read | dmem_write);
        if (i == 0) begin
          cap_addr = dmem_address; cap_be = dmem_byte_enable; cap_wdata = dmem_wdata;
        end
      end
    end
    step();
    cap_req += int'(dmem_read | dmem_write);
    set_idle_exp();
    exp_done = 1'b1;
    exp_err  = !legal || tmo;
    if (legal && tmo) exp_load = 32'd0;
    else if (legal && rd) exp_load = m_load(f3, a, rdat);
    valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    dmem_resp = 1'($urandom); dmem_rdata = $urandom;
  endtask

  initial begin
    chk_en = 1'b0;
    rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0; dmem_resp = 1'b0; dmem_rdata = 32'd0;
    set_idle_exp();
    exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0; exp_load = 32'd0;
    #3;
    check1("rst_dmem_read", dmem_read, 1'b0);
    check1("rst_dmem_write", dmem_write, 1'b0);
    check32("rst_dmem_address", dmem_address, 32'd0);
    check32("rst_dmem_wdata", dmem_wdata, 32'd0);
    check32("rst_byte_enable", 32'(dmem_byte_enable), 32'd0);
    check1("rst_done", done_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    check32("rst_load_data", load_data_o, 32'd0);
    check1("rst_stall", stall_o, 1'b0);
    #10 rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 2);
    check32("sw_addr", cap_addr, 32'h100);
    check32("sw_be", 32'(cap_be), 32'hF);
    check32("sw_wdata", cap_wdata, 32'hDEADBEEF);
    check32("sw_req_cycles", cap_req, 32'd3);
    run_op(1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 32'h80FF_1234, 1);
    check32("lb_data", load_data_o, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h203, 32'd0, 32'h80FF_1234, 0);
    check32("lbu_data", load_data_o, 32'h0000_0080);
    run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 32'h80FF_1234, 3);
    check32("lhu_data", load_data_o, 32'h0000_80FF);
    run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_00AB, 32'd0, 0);
    check32("sb_be", 32'(cap_be), 32'h2);
    check32("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    check32("sb_addr", cap_addr, 32'h300);
    run_op(1'b1, 1'b0, 3'b010, 32'h402, 32'd0, 32'd0, 0);
    check32("lw_mis_req", cap_req, 32'd0);
    check1("lw_mis_err", err_o, 1'b1);
    run_op(1'b1, 1'b1, 3'b010, 32'h400, 32'd0, 32'd0, 0);
    check32("conflict_req", cap_req, 32'd0);
    check1("conflict_err", err_o, 1'b1);
    run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 32'h1234_5678, 9);
    check32("tmo_req_cycles", cap_req, 32'd4);
    check32("tmo_load", load_data_o, 32'd0);
    check1("tmo_err", err_o, 1'b1);
    idle(1);

    // Reset while a load is outstanding.
    step();
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h600;
    dmem_resp = 1'b0;
    set_idle_exp();
    exp_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_stall = 1'b1; exp_rd = 1'b1; exp_addr = 32'h600; exp_be = 4'hF;
      dmem_resp = 1'b0;
    end
    #2;
    chk_en = 1'b0;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("rst_busy_dmem_read", dmem_read, 1'b0);
    check1("rst_busy_stall", stall_o, 1'b0);
    check32("rst_busy_load", load_data_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check1("rst_busy_done", done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle_exp();
    exp_load = 32'd0;
    step();
    chk_en = 1'b1;
    idle(1);
    run_op(1'b1, 1'b0, 3'b010, 32'h604, 32'd0, 32'hCAFE_F00D, 1);
    check32("post_rst_lw", load_data_o, 32'hCAFE_F00D);

    for (int n = 0; n < 200; n++) begin
      int k;
      bit rd, wr;
      k  = $urandom_range(0, 9);
      rd = (k < 5) || (k == 9);
      wr = (k >= 5);
      run_op(rd, wr, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5));
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit of the pipelined RV32I core.
- Consumes the EX/MEM control fields: mem_read, mem_write and funct3.
- Also consumes the ALU-computed address and rs2 store data.
- Runs a request/response handshake with data memory, stalls the pipeline until the access completes, and delivers aligned, sign/zero-extended load data for the memwb mux.
- Detects misaligned, illegal, conflicting and timed-out accesses.

Parameters:
- TIMEOUT, 64: max BUSY cycles without dmem_resp before abort; 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must be ≥ clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  instruction present in MEM stage
- mem_read_i  in  1  control word mem_read
- mem_write_i  in  1  control word mem_write
- funct3_i  in  3  load_funct3_t / store_funct3_t
- addr_i  in  32  byte address (alu_out)
- wdata_i  in  32  rs2 value
- stall_o  out  1  freeze PC and upstream pipeline registers
- done_o  out  1  one-cycle pulse: access finished
- load_data_o  out  32  formatted load result (rv32i_word)
- err_o  out  1  one-cycle pulse: misaligned / illegal / conflict / timeout
- dmem_read  out  1  memory read request
- dmem_write  out  1  memory write request
- dmem_address  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_byte_enable  out  4  rv32i_mem_wmask
- dmem_resp  in  1  memory access complete
- dmem_rdata  in  32  memory read word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - All registered outputs are 0: dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, done_o, err_o, load_data_o.
  - Reset mid-BUSY drops the request immediately; no done_o pulse.
- mem_op = valid_i & (mem_read_i | mem_write_i).
- States:
  - IDLE: if mem_op & legal, latch address/mask/wdata/funct3/offset, set dmem_read or dmem_write, counter=0, go to BUSY. If mem_op & !legal, go to DONE with err_o=1 and no memory request.
  - BUSY: hold the request stable. On dmem_resp, clear the request, register formatted load_data_o (stores leave load_data_o unchanged), go to DONE. Otherwise increment the counter. If TIMEOUT≠0 and counter reaches TIMEOUT-1 without resp, clear the request, set load_data_o=0, set err_o, go to DONE.
  - DONE: done_o=1 for exactly one cycle, inputs ignored, go to IDLE.
- stall_o (combinational) = (IDLE & mem_op) | BUSY. It is low in DONE, so the pipeline advances at the end of DONE.
- Upstream holds all inputs stable while stall_o=1.
- Non-memory instructions (valid_i & !read & !write): stall_o=0, no done_o, state stays IDLE.
- Latency:
  - Accept at T; dmem request visible T+1.
  - Resp sampled at R≥T+1 → DONE at R+1.
  - Minimum 3 cycles; stall_o high for T..R.
- Illegal conditions:
  - mem_read & mem_write both set.
  - load funct3 ∈ {011,110,111}.
  - store funct3 > 010.
  - lh/lhu/sh with addr[0]=1.
  - lw/sw with addr[1:0]≠0.
- Store formatting:
  - sb: mask=0001<<addr[1:0], data={4{wdata[7:0]}}.
  - sh: mask=0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}.
  - sw: mask=1111, data=wdata.
- Load formatting:
  - Shift dmem_rdata right by 8*addr[1:0].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word.
  - dmem_byte_enable=1111 on reads.
- dmem_resp in IDLE/DONE is ignored.

Decomposition:
- Add to rv32i_types:
  - lsu_state_t enum {LSU_IDLE, LSU_BUSY, LSU_DONE}.
  - lsu_err_t enum {none, misalign, illegal, conflict, timeout}, for debug visibility.
- Reuse load_funct3_t, store_funct3_t, rv32i_word, rv32i_mem_wmask.
- Sub-module lsu_align (purely combinational):
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: mask, store data, load data, legal.
  - mem_stage_lsu holds the FSM, latches and watchdog.

Test Plan:
- sw at addr 0x100, wdata=0xDEADBEEF, resp at T+3 → dmem_write=1 over T+1..T+3, byte_enable=1111, dmem_address=0x100, done_o at T+4, stall_o high T..T+3.
- lb at 0x203, rdata=0x80FF_1234 → load_data_o=0xFFFF_FF80; lbu at same address → 0x0000_0080; lhu at 0x202 → 0x0000_80FF.
- sb at 0x301, wdata=0x000000AB → byte_enable=0010, dmem_wdata=0xABABABAB, dmem_address=0x300.
- lw at 0x402 → no dmem_read ever, stall_o high only at T, err_o and done_o pulse at T+1; same response for read&write both set.
- TIMEOUT=4, lw with no resp → dmem_read high 4 cycles then low, err_o=1, load_data_o=0, stall_o drops.
- rst_n low mid-BUSY → dmem_read=0 asynchronously, no done_o; after release a new lw completes normally.
